mult_share_arb: RTL

Round-robin arbiter and sequencer that shares one pipelined multiply-add unit (the `lpm_mult` arithmetic primitive) among `NREQ` convolution lanes. Each lane presents an operand triple (a, b, sum) with a valid/ready handshake. The block issues at most one triple per cycle into the shared unit and tracks the owner of every in-flight operation. Each result is returned to its originating lane as a one-cycle response pulse.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/mult_share_arb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the convolution datapath blocks.
//   MULT_PIPE_MAX : deepest supported latency of the shared multiply-add unit
//   clog2         : ceiling log2, usable in parameter expressions
//   tag_width     : lane-index width, never narrower than one bit
package cnn_pkg;

    localparam int unsigned MULT_PIPE_MAX = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned tag_width(input int unsigned nreq);
        return (clog2(nreq) > 0) ? clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per lane
//   ptr       : highest-priority lane this cycle (must be < NREQ)
//   grant     : one-hot grant of the first requester at or after ptr, cyclically
//   grant_idx : binary index of the granted lane (0 when nothing is granted)
//   any_grant : at least one lane is requesting
module rr_arbiter
    import cnn_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TAGW = tag_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [TAGW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [TAGW-1:0] grant_idx,
    output logic            any_grant
);

    // One spare bit so ptr + offset cannot overflow before the wrap.
    logic [TAGW:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (TAGW+1)'(ptr) + (TAGW+1)'(k);
            if (cand >= (TAGW+1)'(NREQ)) begin
                cand = cand - (TAGW+1)'(NREQ);
            end
            if (!any_grant && req[cand[TAGW-1:0]]) begin
                any_grant              = 1'b1;
                grant_idx              = cand[TAGW-1:0];
                grant[cand[TAGW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one pipelined multiply-add unit among NREQ lanes.
// Each cycle at most one lane's (a, b, sum) triple is registered onto the unit
// inputs; the owner tag travels down a PIPE-deep shift register alongside the
// unit so the result can be steered back as a one-cycle rsp_valid pulse.
//   clock, aclr                 : clock and synchronous active-high reset
//   req_valid / req_ready       : per-lane handshake, req_ready is one-hot
//   req_dataa/datab/sum         : packed per-lane operands
//   mul_dataa/datab/sum, clken  : registered operands and clock enable to the unit
//   mul_result                  : unit output, PIPE edges after the operands
//   rsp_valid / rsp_result      : one-hot response strobe and unit result
// PIPE must lie in 1..MULT_PIPE_MAX.
module mult_share_arb
    import cnn_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WIDTHA = 8,
    parameter int unsigned WIDTHB = 8,
    parameter int unsigned WIDTHS = 16,
    parameter int unsigned WIDTHP = 16,
    parameter int unsigned PIPE   = 1
) (
    input  logic                     clock,
    input  logic                     aclr,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTHA-1:0]   req_dataa,
    input  logic [NREQ*WIDTHB-1:0]   req_datab,
    input  logic [NREQ*WIDTHS-1:0]   req_sum,
    output logic [WIDTHA-1:0]        mul_dataa,
    output logic [WIDTHB-1:0]        mul_datab,
    output logic [WIDTHS-1:0]        mul_sum,
    output logic                     mul_clken,
    input  logic [WIDTHP-1:0]        mul_result,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [WIDTHP-1:0]        rsp_result
);

    localparam int unsigned TAGW = tag_width(NREQ);

    logic [TAGW-1:0] ptr;
    logic            iss_vld;
    logic [TAGW-1:0] iss_tag;
    logic [PIPE-1:0] stg_vld;
    logic [TAGW-1:0] stg_tag [PIPE];

    logic [NREQ-1:0] arb_grant;
    logic [TAGW-1:0] arb_idx;
    logic            arb_any;
    logic [TAGW-1:0] next_ptr;

    logic [WIDTHA-1:0] sel_a;
    logic [WIDTHB-1:0] sel_b;
    logic [WIDTHS-1:0] sel_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    assign req_ready = aclr ? '0 : arb_grant;
    assign next_ptr  = (arb_idx == TAGW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

    // Grant is one-hot, so an AND-OR select is enough.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (arb_grant[i]) begin
                sel_a = req_dataa[i*WIDTHA +: WIDTHA];
                sel_b = req_datab[i*WIDTHB +: WIDTHB];
                sel_s = req_sum[i*WIDTHS +: WIDTHS];
            end
        end
    end

    // Operands only load on a transfer so the unit inputs stay quiet when idle.
    always_ff @(posedge clock) begin
        if (aclr) begin
            ptr       <= '0;
            iss_vld   <= 1'b0;
            iss_tag   <= '0;
            mul_dataa <= '0;
            mul_datab <= '0;
            mul_sum   <= '0;
        end else begin
            iss_vld <= arb_any;
            if (arb_any) begin
                mul_dataa <= sel_a;
                mul_datab <= sel_b;
                mul_sum   <= sel_s;
                iss_tag   <= arb_idx;
                ptr       <= next_ptr;
            end
        end
    end

    // Owner tags shadow the unit's internal pipeline stage for stage.
    always_ff @(posedge clock) begin
        if (aclr) begin
            stg_vld <= '0;
            for (int i = 0; i < int'(PIPE); i++) begin
                stg_tag[i] <= '0;
            end
        end else begin
            stg_vld[0] <= iss_vld;
            stg_tag[0] <= iss_tag;
            for (int i = 1; i < int'(PIPE); i++) begin
                stg_vld[i] <= stg_vld[i-1];
                stg_tag[i] <= stg_tag[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (stg_vld[PIPE-1]) begin
            rsp_valid[stg_tag[PIPE-1]] = 1'b1;
        end
    end

    assign rsp_result = mul_result;
    assign mul_clken  = iss_vld | (|stg_vld);

endmodule
